// File: rtl/tape_capture.sv
// tape_capture: cassette-save decoder turning port-$FF tape output pulses into bytes.
// Define TAPE_CAPTURE_FIFO_EN to place a 4-entry FWFT FIFO in front of byte_q/byte_valid.
module tape_capture #(
    parameter int               CNT_W   = 13,
    parameter logic [CNT_W-1:0] WIN_LO  = 13'h0500,
    parameter logic [CNT_W-1:0] WIN_HI  = 13'h0900,
    parameter logic [CNT_W-1:0] TIMEOUT = 13'h1800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        motor,
    input  logic [1:0]  level,
    output logic [7:0]  byte_q,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        overflow,
    output logic [15:0] count,
    output logic        active
);

    // state     | meaning
    // IDLE      | motor off, nothing decoded
    // WAIT_SYNC | expecting the sync pulse that opens a bit cell
    // WAIT_DATA | sync seen; a data pulse means '1', the next sync means '0'
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_SYNC = 2'd1;
    localparam logic [1:0] WAIT_DATA = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state_q, state_d;
    logic [1:0]       prev_level_q;
    logic             prev_motor_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic [2:0]       bitcnt_q, bitcnt_d;
    logic             overflow_q, overflow_d;
    logic [15:0]      count_q, count_d;

    logic       pulse, motor_rise, motor_fall;
    logic       bit_vld, bit_val, byte_done;
    logic [7:0] byte_new;
    logic       pop, can_push, push;

    assign pulse      = ce & (level != 2'b00) & (prev_level_q == 2'b00);
    assign motor_rise = ce & motor & ~prev_motor_q;
    assign motor_fall = ce & ~motor & prev_motor_q;

    assign byte_new  = {shift_q, bit_val};
    assign byte_done = bit_vld & (bitcnt_q == 3'd7);
    assign push      = byte_done & can_push;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        overflow_d = overflow_q;
        count_d    = count_q;
        bit_vld    = 1'b0;
        bit_val    = 1'b0;

        if (ce && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (motor_rise) begin
                    state_d    = WAIT_SYNC;
                    cnt_d      = '0;
                    shift_d    = '0;
                    bitcnt_d   = '0;
                    overflow_d = 1'b0;
                    count_d    = '0;
                end
            end
            WAIT_SYNC: begin
                if (motor_fall) begin
                    state_d  = IDLE;
                    shift_d  = '0;
                    bitcnt_d = '0;
                end else if (pulse) begin
                    state_d = WAIT_DATA;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT) begin
                    shift_d  = '0;
                    bitcnt_d = '0;
                end
            end
            WAIT_DATA: begin
                if (motor_fall) begin
                    state_d  = IDLE;
                    shift_d  = '0;
                    bitcnt_d = '0;
                end else if (pulse) begin
                    // A late pulse is the next sync, so the pending cell was a '0'.
                    if (cnt_q >= WIN_HI) begin
                        bit_vld = 1'b1;
                        cnt_d   = '0;
                    end else if (cnt_q >= WIN_LO) begin
                        bit_vld = 1'b1;
                        bit_val = 1'b1;
                        state_d = WAIT_SYNC;
                    end
                end else if (cnt_q == TIMEOUT) begin
                    bit_vld = 1'b1;
                    state_d = WAIT_SYNC;
                end
            end
            default: state_d = IDLE;
        endcase

        if (bit_vld) begin
            shift_d  = {shift_q[5:0], bit_val};
            bitcnt_d = bitcnt_q + 3'd1;
        end

        if (push) begin
            count_d = count_q + 16'd1;
        end else if (byte_done) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            prev_level_q <= 2'b00;
            prev_motor_q <= 1'b0;
            cnt_q        <= '0;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            overflow_q   <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
            if (ce) begin
                prev_level_q <= level;
                prev_motor_q <= motor;
            end
        end
    end

`ifdef TAPE_CAPTURE_FIFO_EN
    logic [7:0] fifo_q [4];
    logic [1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0] fill_q;
    logic       flush;

    assign flush      = (state_q == IDLE) & motor_rise;
    assign byte_valid = (fill_q != 3'd0);
    assign byte_q     = fifo_q[rd_ptr_q];
    assign pop        = byte_valid & byte_ready;
    // When full, a same-cycle pop frees the slot the write pointer is aimed at.
    assign can_push   = (fill_q != 3'd4) | pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                fifo_q[i] <= 8'h00;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            fill_q   <= 3'd0;
        end else if (flush) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            fill_q   <= 3'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= byte_new;
                wr_ptr_q         <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            fill_q <= fill_q + {2'b00, push} - {2'b00, pop};
        end
    end
`else
    logic [7:0] byte_q_q;
    logic       byte_valid_q;

    assign byte_q     = byte_q_q;
    assign byte_valid = byte_valid_q;
    assign pop        = byte_valid_q & byte_ready;
    assign can_push   = ~byte_valid_q | pop;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            byte_q_q     <= 8'h00;
            byte_valid_q <= 1'b0;
        end else begin
            if (push) begin
                byte_q_q <= byte_new;
            end
            byte_valid_q <= push | (byte_valid_q & ~pop);
        end
    end
`endif

    assign overflow = overflow_q;
    assign count    = count_q;
    assign active   = (state_q != IDLE);

endmodule

// File: tb/tb_tape_capture.sv
// Directed bench for tape_capture; timing windows are scaled by 1/16 to keep runs short.
module tb_tape_capture;

    localparam int DATA_OFS  = 'h70;
    localparam int PERIOD    = 'hE0;
    localparam int TIMEOUT_T = 'h180;

    logic        clock;
    logic        reset;
    logic        ce;
    logic        motor;
    logic [1:0]  level;
    logic [7:0]  byte_q;
    logic        byte_valid;
    logic        byte_ready;
    logic        overflow;
    logic [15:0] count;
    logic        active;

    tape_capture #(
        .CNT_W  (13),
        .WIN_LO (13'h0050),
        .WIN_HI (13'h0090),
        .TIMEOUT(13'h0180)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ce        (ce),
        .motor     (motor),
        .level     (level),
        .byte_q    (byte_q),
        .byte_valid(byte_valid),
        .byte_ready(byte_ready),
        .overflow  (overflow),
        .count     (count),
        .active    (active)
    );

    typedef struct {
        logic [7:0] data;
        logic [1:0] lvl;
        logic [7:0] exp_q;
    } vec_t;

    int n_pass;
    int n_total;
    int pend_gap;
    int valid_cycles;
    logic [7:0] last_q;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (byte_valid) begin
            valid_cycles = valid_cycles + 1;
            last_q = byte_q;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic ce_cycle();
        ce = 1'b1;
        @(posedge clock); #1;
        ce = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) ce_cycle();
    endtask

    task automatic pulse(input logic [1:0] lv);
        level = lv;
        ce_cycle();
        level = 2'b00;
    endtask

    // Sends the top nbits of data; glitch_bit adds a too-early pulse inside that bit cell.
    task automatic send_bits(input logic [7:0] data, input int nbits, input logic [1:0] lv,
                             input int glitch_bit);
        for (int i = 7; i > 7 - nbits; i--) begin
            gap(pend_gap);
            pulse(lv);
            if (data[i]) begin
                if (i == glitch_bit) begin
                    gap('h10);
                    pulse(lv);
                    gap(DATA_OFS - 'h12);
                end else begin
                    gap(DATA_OFS - 1);
                end
                pulse(lv);
                pend_gap = PERIOD - DATA_OFS - 1;
            end else begin
                pend_gap = PERIOD - 1;
            end
        end
    endtask

    task automatic finish_byte();
        gap(pend_gap);
        pulse(2'b01);
        pend_gap = PERIOD - 1;
    endtask

    task automatic motor_off();
        motor = 1'b0;
        ce_cycle();
    endtask

    task automatic motor_on();
        motor = 1'b1;
        ce_cycle();
        pend_gap = 0;
    endtask

    task automatic consume();
        byte_ready = 1'b1;
        @(posedge clock); #1;
        byte_ready = 1'b0;
    endtask

    vec_t vecs [4];
    int   base;

    initial begin
        n_pass = 0;
        n_total = 0;
        pend_gap = 0;
        valid_cycles = 0;
        last_q = 8'h00;
        reset = 1'b0;
        ce = 1'b0;
        motor = 1'b0;
        level = 2'b00;
        byte_ready = 1'b0;

        vecs[0] = '{data: 8'hA5, lvl: 2'b01, exp_q: 8'hA5};
        vecs[1] = '{data: 8'h3C, lvl: 2'b10, exp_q: 8'h3C};
        vecs[2] = '{data: 8'h81, lvl: 2'b11, exp_q: 8'h81};
        vecs[3] = '{data: 8'h6E, lvl: 2'b01, exp_q: 8'h6E};

        #7;
        check("reset byte_q", {24'd0, byte_q}, 32'h00);
        check("reset byte_valid", {31'd0, byte_valid}, 32'd0);
        check("reset overflow", {31'd0, overflow}, 32'd0);
        check("reset count", {16'd0, count}, 32'd0);
        check("reset active", {31'd0, active}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // A5 streamed with the consumer always ready
        byte_ready = 1'b1;
        motor_on();
        check("motor_on active", {31'd0, active}, 32'd1);
        base = valid_cycles;
        send_bits(8'hA5, 8, 2'b01, -1);
        gap(4);
        check("A5 valid cycles", valid_cycles - base, 32'd1);
        check("A5 byte_q", {24'd0, last_q}, 32'hA5);
        check("A5 count", {16'd0, count}, 32'd1);
        check("A5 overflow", {31'd0, overflow}, 32'd0);
        check("A5 valid after pop", {31'd0, byte_valid}, 32'd0);
        byte_ready = 1'b0;

        // 00: last bit is resolved only by the timeout
        motor_off();
        motor_on();
        send_bits(8'h00, 8, 2'b10, -1);
        check("00 not yet done", {31'd0, byte_valid}, 32'd0);
        gap(TIMEOUT_T + 'h10);
        check("00 valid", {31'd0, byte_valid}, 32'd1);
        check("00 byte_q", {24'd0, byte_q}, 32'h00);
        check("00 count", {16'd0, count}, 32'd1);
        check("00 active", {31'd0, active}, 32'd1);

        // FF with an early glitch pulse inside bit 4
        consume();
        motor_off();
        motor_on();
        send_bits(8'hFF, 8, 2'b11, 4);
        finish_byte();
        check("glitch byte_q", {24'd0, byte_q}, 32'hFF);
        check("glitch count", {16'd0, count}, 32'd1);

        for (int v = 0; v < 4; v++) begin
            consume();
            motor_off();
            motor_on();
            send_bits(vecs[v].data, 8, vecs[v].lvl, -1);
            finish_byte();
            check($sformatf("vec%0d valid", v), {31'd0, byte_valid}, 32'd1);
            check($sformatf("vec%0d byte_q", v), {24'd0, byte_q}, {24'd0, vecs[v].exp_q});
            check($sformatf("vec%0d count", v), {16'd0, count}, 32'd1);
            consume();
            check($sformatf("vec%0d popped", v), {31'd0, byte_valid}, 32'd0);
        end

        // Backpressure: 12 then 34 with byte_ready held low
        consume();
        motor_off();
        motor_on();
        send_bits(8'h12, 8, 2'b01, -1);
        send_bits(8'h34, 8, 2'b10, -1);
        finish_byte();
        check("bp byte_q", {24'd0, byte_q}, 32'h12);
`ifdef TAPE_CAPTURE_FIFO_EN
        check("bp overflow", {31'd0, overflow}, 32'd0);
        check("bp count", {16'd0, count}, 32'd2);
        consume();
        check("bp second byte", {24'd0, byte_q}, 32'h34);
        check("bp second valid", {31'd0, byte_valid}, 32'd1);
`else
        check("bp overflow", {31'd0, overflow}, 32'd1);
        check("bp count", {16'd0, count}, 32'd1);
        consume();
        check("bp drained", {31'd0, byte_valid}, 32'd0);
`endif

        // Partial F0 aborted by motor_fall, then a clean 3C
        motor_off();
        motor_on();
        check("restart overflow", {31'd0, overflow}, 32'd0);
        check("restart count", {16'd0, count}, 32'd0);
        check("restart valid", {31'd0, byte_valid}, 32'd0);
        send_bits(8'hF0, 4, 2'b01, -1);
        motor_off();
        check("fall active", {31'd0, active}, 32'd0);
        motor_on();
        send_bits(8'h3C, 8, 2'b10, -1);
        finish_byte();
        check("3C valid", {31'd0, byte_valid}, 32'd1);
        check("3C byte_q", {24'd0, byte_q}, 32'h3C);
        check("3C count", {16'd0, count}, 32'd1);

        // Asynchronous reset mid-byte while a byte is still held
        send_bits(8'hE0, 3, 2'b01, -1);
        @(posedge clock); #3;
        reset = 1'b0;
        #1;
        check("areset byte_valid", {31'd0, byte_valid}, 32'd0);
        check("areset byte_q", {24'd0, byte_q}, 32'h00);
        check("areset count", {16'd0, count}, 32'd0);
        check("areset overflow", {31'd0, overflow}, 32'd0);
        check("areset active", {31'd0, active}, 32'd0);
        #20;
        reset = 1'b1;
        @(posedge clock); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
